// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: blank code, hex glyph table
// and a width helper for the counters.
package seg_pkg;

  localparam logic [7:0] SEG_OFF     = 8'hFF;
  localparam logic [7:0] SEG_DP_ONLY = 8'h7F;

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit is left off here and forced by the encoder
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hex7_encoder.sv
// Combinational hex nibble plus decimal point to active-low segment code.
module hex7_encoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, HEX_SEG[nibble][6:0]};

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with frame-latched inputs,
// leading-zero blanking, per-digit blink, brightness PWM and dead time.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int CLK_DIV   = 5000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic                  clk100MHZ,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] dig,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  blank_en,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic [2:0]            bright,
  output logic [7:0]            SEG,
  output logic [N_DIGITS-1:0]   AN
);

  localparam int PW      = clog2(CLK_DIV);
  localparam int IW      = clog2(N_DIGITS);
  localparam int BW      = clog2(BLINK_DIV);
  localparam int ON_STEP = CLK_DIV / 8;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_ph;
  logic [4*N_DIGITS-1:0] sh_dig;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_blink_mask;
  logic                  sh_blank_en;
  logic [2:0]            sh_bright;
  logic                  primed;

  logic                  slot_end;
  logic                  frame_end;
  logic                  blink_wrap;
  logic                  upper_zero;
  logic                  blanked;
  logic                  enable;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blink;
  logic [31:0]           on_limit;
  logic [7:0]            enc_seg;
  logic [7:0]            seg_code;
  logic [N_DIGITS-1:0]   an_code;

  assign slot_end   = (presc == PW'(CLK_DIV - 1));
  assign frame_end  = slot_end && (idx == IW'(N_DIGITS - 1));
  assign blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));

  always_ff @(posedge clk100MHZ) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk100MHZ) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      if (blink_wrap) blink_ph <= ~blink_ph;
    end
  end

  // Display stays dark until the first frame boundary after reset has loaded the shadows
  always_ff @(posedge clk100MHZ) begin
    if (rst) begin
      sh_dig        <= '0;
      sh_dp         <= '0;
      sh_blank_en   <= 1'b0;
      sh_blink_mask <= '0;
      sh_bright     <= '0;
      primed        <= 1'b0;
    end else if (frame_end) begin
      sh_dig        <= dig;
      sh_dp         <= dp;
      sh_blank_en   <= blank_en;
      sh_blink_mask <= blink_mask;
      sh_bright     <= bright;
      primed        <= 1'b1;
    end
  end

  // Current digit is a leading zero when it and every more-significant nibble is zero
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if ((IW'(i) >= idx) && (sh_dig[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end
  end

  assign cur_nib   = sh_dig[4*idx +: 4];
  assign cur_dp    = sh_dp[idx];
  assign cur_blink = sh_blink_mask[idx];
  assign blanked   = sh_blank_en && (idx != '0) && upper_zero;
  assign on_limit  = (32'(sh_bright) + 32'd1) * 32'(ON_STEP);

  assign enable = primed
               && (presc != '0)
               && (32'(presc) < on_limit)
               && !(cur_blink && blink_ph)
               && !(blanked && !cur_dp);

  hex7_encoder u_enc (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (enc_seg)
  );

  assign seg_code = blanked ? SEG_DP_ONLY : enc_seg;
  assign an_code  = ~(N_DIGITS'(1) << idx);

  always_ff @(posedge clk100MHZ) begin
    if (rst) begin
      SEG <= SEG_OFF;
      AN  <= '1;
    end else if (enable) begin
      SEG <= seg_code;
      AN  <= an_code;
    end else begin
      SEG <= SEG_OFF;
      AN  <= '1;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a cycle model queues the expected
// SEG/AN per clock, plus directed per-frame on-time and glyph checks.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int CD = 16;
  localparam int BD = 64;

  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk100MHZ = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dig = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        blank_en = 1'b0;
  logic [3:0]  blink_mask = 4'h0;
  logic [2:0]  bright = 3'd0;
  logic [7:0]  SEG;
  logic [3:0]  AN;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];

  int          m_presc = 0, m_idx = 0, m_bcnt = 0;
  logic        m_ph = 1'b0, m_primed = 1'b0, m_blank = 1'b0;
  logic [15:0] m_dig = 16'h0;
  logic [3:0]  m_dp = 4'h0, m_bmask = 4'h0;
  logic [2:0]  m_bright = 3'd0;

  int          an_cnt [4];
  logic [7:0]  seg_seen [4];

  seven_seg_scanner #(.N_DIGITS(ND), .CLK_DIV(CD), .BLINK_DIV(BD)) dut (
    .clk100MHZ  (clk100MHZ),
    .rst        (rst),
    .dig        (dig),
    .dp         (dp),
    .blank_en   (blank_en),
    .blink_mask (blink_mask),
    .bright     (bright),
    .SEG        (SEG),
    .AN         (AN)
  );

  always #5 clk100MHZ = ~clk100MHZ;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [11:0] model_out();
    int         nib;
    logic       blanked, lit;
    logic [7:0] seg;
    if (!m_primed) return 12'hFFF;
    nib     = int'((m_dig >> (4 * m_idx)) & 16'hF);
    blanked = m_blank && (m_idx > 0) && ((m_dig >> (4 * m_idx)) == 16'h0);
    lit     = (m_presc > 0) && (m_presc < (int'(m_bright) + 1) * (CD / 8))
           && !(m_bmask[m_idx] && m_ph) && !(blanked && !m_dp[m_idx]);
    if (!lit) return 12'hFFF;
    seg    = blanked ? 8'h7F : GLYPH[nib];
    seg[7] = ~m_dp[m_idx];
    return {~(4'b0001 << m_idx), seg};
  endfunction

  // Reference model: expected output of each edge is queued from pre-edge state
  initial begin
    forever begin
      @(posedge clk100MHZ);
      if (rst) begin
        exp_q.push_back(12'hFFF);
        m_presc = 0; m_idx = 0; m_bcnt = 0; m_ph = 1'b0; m_primed = 1'b0;
        m_dig = 16'h0; m_dp = 4'h0; m_blank = 1'b0; m_bmask = 4'h0; m_bright = 3'd0;
      end else begin
        exp_q.push_back(model_out());
        if (m_presc == CD - 1 && m_idx == ND - 1) begin
          m_dig = dig; m_dp = dp; m_blank = blank_en; m_bmask = blink_mask;
          m_bright = bright; m_primed = 1'b1;
        end
        if (m_presc == CD - 1) m_idx = (m_idx + 1) % ND;
        m_presc = (m_presc + 1) % CD;
        if (m_bcnt == BD - 1) begin
          m_bcnt = 0;
          m_ph   = ~m_ph;
        end else begin
          m_bcnt++;
        end
      end
    end
  end

  initial begin : scoreboard
    logic [11:0] e;
    forever begin
      @(negedge clk100MHZ);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("an", 32'(AN), 32'(e[11:8]));
        checkOutput("seg", 32'(SEG), 32'(e[7:0]));
        checkOutput("onehot", 32'($countones(~AN) <= 1), 32'd1);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input logic be,
                               input logic [3:0] bm, input logic [2:0] br);
    @(negedge clk100MHZ);
    dig = d; dp = p; blank_en = be; blink_mask = bm; bright = br;
    repeat (128) @(negedge clk100MHZ);
  endtask

  task automatic observe_frame(input int ncycles);
    logic [3:0] pat;
    for (int k = 0; k < 4; k++) begin
      an_cnt[k]   = 0;
      seg_seen[k] = 8'h00;
    end
    repeat (ncycles) begin
      @(negedge clk100MHZ);
      for (int k = 0; k < 4; k++) begin
        pat = ~(4'b0001 << k);
        if (AN === pat) begin
          an_cnt[k]++;
          seg_seen[k] = SEG;
        end
      end
    end
  endtask

  task automatic check_frame(input string ph, input logic [31:0] cnts, input logic [31:0] segs);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s_cnt%0d", ph, k), 32'(an_cnt[k]), 32'(cnts[8*k +: 8]));
      if (cnts[8*k +: 8] != 8'd0)
        checkOutput($sformatf("%s_seg%0d", ph, k), 32'(seg_seen[k]), 32'(segs[8*k +: 8]));
    end
  endtask

  task automatic wait_an(input logic [3:0] pat);
    int n;
    n = 0;
    do begin
      @(negedge clk100MHZ);
      n++;
    end while (AN !== pat && n < 200);
    checkOutput($sformatf("wait_an_%b", pat), 32'(AN), 32'(pat));
  endtask

  initial begin
    dig = 16'h1234; dp = 4'h0; blank_en = 1'b0; blink_mask = 4'h0; bright = 3'd7;
    repeat (3) @(negedge clk100MHZ);
    checkOutput("reset_seg", 32'(SEG), 32'h0FF);
    checkOutput("reset_an", 32'(AN), 32'h00F);
    rst = 1'b0;

    repeat (70) @(negedge clk100MHZ);
    observe_frame(64);
    check_frame("p1", {8'd15, 8'd15, 8'd15, 8'd15}, {8'hF9, 8'hA4, 8'hB0, 8'h99});

    applyStimulus(16'h0050, 4'b1000, 1'b1, 4'b0000, 3'd7);
    observe_frame(64);
    check_frame("p2", {8'd15, 8'd0, 8'd15, 8'd15}, {8'h7F, 8'h00, 8'h92, 8'hC0});

    applyStimulus(16'h1234, 4'b0000, 1'b0, 4'b0000, 3'd1);
    observe_frame(64);
    check_frame("p3_b1", {8'd3, 8'd3, 8'd3, 8'd3}, {8'hF9, 8'hA4, 8'hB0, 8'h99});
    applyStimulus(16'h1234, 4'b0000, 1'b0, 4'b0000, 3'd0);
    observe_frame(64);
    check_frame("p3_b0", {8'd1, 8'd1, 8'd1, 8'd1}, {8'hF9, 8'hA4, 8'hB0, 8'h99});

    applyStimulus(16'h1234, 4'b0000, 1'b0, 4'b0001, 3'd7);
    observe_frame(128);
    check_frame("p4", {8'd30, 8'd30, 8'd30, 8'd15}, {8'hF9, 8'hA4, 8'hB0, 8'h99});

    applyStimulus(16'h1234, 4'b0000, 1'b0, 4'b0000, 3'd7);
    wait_an(4'b1101);
    dig = 16'h5678;
    wait_an(4'b0111);
    checkOutput("p5_old_d3", 32'(SEG), 32'h0F9);
    wait_an(4'b1110);
    checkOutput("p5_new_d0", 32'(SEG), 32'h080);
    wait_an(4'b0111);
    checkOutput("p5_new_d3", 32'(SEG), 32'h092);

    wait_an(4'b1011);
    rst = 1'b1;
    @(negedge clk100MHZ);
    checkOutput("p6_seg", 32'(SEG), 32'h0FF);
    checkOutput("p6_an", 32'(AN), 32'h00F);
    rst = 1'b0;
    observe_frame(64);
    check_frame("p6_dark", 32'h0, 32'h0);
    observe_frame(64);
    check_frame("p6_new", {8'd15, 8'd15, 8'd15, 8'd15}, {8'h92, 8'h82, 8'hF8, 8'h80});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
